output_port_alloc: RTL and testbench
====================================

// Module: output_port_alloc
// PURPOSE
//  Per-output-port allocation stage of the router. It sits downstream of the round-robin arbiter
//  (NR=5 inputs). It builds the arbiter's request vector from input head flits routed to this port.
//  It consumes the one-hot grant and locks the winner for a whole wormhole packet (head..tail).
//  It forwards flits through a registered crossbar mux and tracks downstream buffer credits.
// PARAMETERS
//  NR         5   number of input ports / arbiter width
//  DW         34  flit width; [DW-1:DW-2] = flit type, [DW-3:0] = payload
//  CRD_DEPTH  4   downstream buffer depth = initial credit count (>=1)
// PORTS
//  CLK       in   1      clock, all logic on rising edge
//  RST       in   1      synchronous reset, active-high
//  IN_VLD    in   NR     input i holds a flit at its FIFO head
//  IN_REQ    in   NR     route computation: input i's packet targets this port
//  IN_FLIT   in   NR*DW  head flits; input i at [i*DW +: DW]
//  IN_POP    out  NR     one-hot/zero: dequeue input i this cycle (combinational)
//  ARB_REQ   out  NR     request vector to arbiter REQ (combinational)
//  ARB_GRT   in   NR     arbiter grant GRT, one-hot or zero, same cycle as ARB_REQ
//  CRD_IN    in   1      one-cycle pulse: downstream freed one buffer slot
//  OUT_VLD   out  1      registered flit valid to link
//  OUT_FLIT  out  DW     registered flit
//  OUT_SEL   out  NR     one-hot current owner (zero when IDLE)
//  BUSY      out  1      FSM in LOCKED
//  ERR       out  2      sticky: [0] credit overflow, [1] illegal grant
// BEHAVIOUR
//  Flit types: BODY=2'b00, TAIL=2'b01, HEAD=2'b10, SINGLE=2'b11 (head+tail).
//  Reset: FSM=IDLE, owner=0, CRD=CRD_DEPTH, OUT_VLD=0, OUT_FLIT=0, OUT_SEL=0, BUSY=0, ERR=0.
//   - Applies mid-packet too; the partially sent packet is abandoned without a tail.
//  crd_ok = (CRD != 0). CRD width = $clog2(CRD_DEPTH+1).
//  IDLE:
//   - ARB_REQ[i] = IN_VLD[i] & IN_REQ[i] & type_i in {HEAD,SINGLE} & crd_ok.
//   - A grant g is legal if it is one-hot and (g & ~ARB_REQ)==0.
//     - Legal g: IN_POP=g, send flit g, owner<=g.
//     - Next state is LOCKED if the flit is HEAD; stay IDLE if SINGLE.
//   - g==0: no action. Illegal g (multi-hot, or grant to a non-requester): ignore it, no pop, set ERR[1].
//   - BODY/TAIL at an input's head while IDLE is never requested; that input stalls.
//  LOCKED:
//   - ARB_REQ=0 and the arbiter is not consulted.
//   - If IN_VLD[owner] & crd_ok: IN_POP=owner and send the flit. A TAIL sends the FSM to IDLE.
//   - Flits are not type-checked while LOCKED.
//   - If the owner is not valid or CRD==0: hold, no pop, no bubble error.
//  Send:
//   - OUT_VLD<=1 and OUT_FLIT<=flit on the next edge (latency 1 cycle from IN_POP).
//   - In any cycle with no send, OUT_VLD<=0 and OUT_FLIT holds its value.
//  OUT_SEL and BUSY are registered and reflect state after the edge; OUT_SEL=0 in IDLE.
//  A back-to-back SINGLE, or a tail followed by a new head, may issue in consecutive cycles.
//   - The new head must win IDLE arbitration first.
//  Credits:
//   - Send only: CRD-1. CRD_IN only: CRD+1. Both in the same cycle: unchanged.
//   - CRD_IN while CRD==CRD_DEPTH and no send: CRD saturates and ERR[0] is set.
//   - A send is never issued at CRD==0, so there is no underflow.
//  ERR bits clear only on RST.
// STRUCTURE
//  router_pkg:
//   - flit_type_t enum (BODY/TAIL/HEAD/SINGLE), localparams NR_DEF=5 and DW_DEF=34.
//   - function is_head(type) returning 1 for HEAD and SINGLE.
//  Sub-module credit_counter (param DEPTH; ports inc, dec, ok, overflow).
//  FSM, request masking and mux/output registers stay in the top module.
//  The arbiter is instantiated by the parent, so its pointer update stays in one place.
// TESTING
//  1 Reset, CRD_IN idle -> after 1 edge: OUT_VLD=0, OUT_SEL=0, BUSY=0, ERR=0, internal CRD=4.
//  2 SINGLE on in0, IN_REQ=00001, tb grants 00001 -> IN_POP=00001 same cycle.
//     - Next edge: OUT_VLD=1, OUT_FLIT=in0 flit, BUSY stays 0.
//  3 HEAD,BODY,BODY,TAIL on in2; HEAD present on in3 from cycle 1 -> ARB_REQ=00000 from cycle 1 until the TAIL pops.
//     - Next cycle: ARB_REQ=01000. OUT_FLIT in order H,B,B,T; OUT_SEL=00100 throughout.
//  4 5-flit packet with no CRD_IN -> 4 flits sent, then stall with IN_POP=0.
//     - A CRD_IN pulse releases flit 5 exactly 1 cycle later.
//  5 CRD_IN at CRD=4, no send -> ERR=2'b01, CRD remains 4.
//     - CRD_IN together with a send -> CRD unchanged.
//  6 ARB_GRT=00011, or 10000 while ARB_REQ=00001 -> no pop, ERR[1]=1.
//     - RST asserted mid-packet -> IDLE, CRD=4, and ERR is cleared.

Source files
------------

// File: rtl/output_port_alloc_pkg.sv
// Shared types and helpers for the output port allocation stage.
//   flit_type_t : two-bit flit type carried in the top bits of every flit
//   is_head     : 1 for flit types that open a packet (HEAD or SINGLE)
package output_port_alloc_pkg;

    localparam int unsigned NR_DEF = 5;
    localparam int unsigned DW_DEF = 34;

    typedef enum logic [1:0] {
        BODY   = 2'b00,
        TAIL   = 2'b01,
        HEAD   = 2'b10,
        SINGLE = 2'b11
    } flit_type_t;

    function automatic logic is_head(input flit_type_t t);
        return (t == HEAD) || (t == SINGLE);
    endfunction

endpackage

// File: rtl/output_port_alloc_credit_counter.sv
// Downstream credit counter: starts full, one credit per sent flit, one back per inc pulse.
//   clk, rst  : clock, synchronous active-high reset (count returns to DEPTH)
//   inc       : downstream freed a slot
//   dec       : a flit is sent this cycle
//   ok        : at least one credit available
//   overflow  : inc with no dec while already full (count saturates)
module output_port_alloc_credit_counter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic ok,
    output logic overflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    // Simultaneous inc and dec cancel out.
    always_comb begin
        cnt_nx   = cnt;
        overflow = 1'b0;
        if (inc && !dec) begin
            if (cnt == CW'(DEPTH)) begin
                overflow = 1'b1;
            end else begin
                cnt_nx = cnt + CW'(1);
            end
        end else if (dec && !inc) begin
            cnt_nx = cnt - CW'(1);
        end
    end

    assign ok = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= CW'(DEPTH);
        end else begin
            cnt <= cnt_nx;
        end
    end

endmodule

// File: rtl/output_port_alloc.sv
// Per-output-port allocator: builds arbiter requests from head flits, locks the
// winner for a wormhole packet, forwards flits through a registered mux and
// tracks downstream credits.
//   clk, rst  : clock, synchronous active-high reset
//   in_vld    : per-input flit present at FIFO head
//   in_req    : per-input route targets this port
//   in_flit   : per-input head flit, input i at [i*DW +: DW]
//   in_pop    : one-hot/zero dequeue strobe (combinational)
//   arb_req   : request vector to the arbiter (combinational)
//   arb_grt   : arbiter grant, same cycle as arb_req
//   crd_in    : downstream returned one credit
//   out_vld   : registered flit valid
//   out_flit  : registered flit
//   out_sel   : one-hot current packet owner, zero when idle
//   busy      : locked onto a packet
//   err       : sticky [0] credit overflow, [1] illegal grant
module output_port_alloc
    import output_port_alloc_pkg::*;
#(
    parameter int unsigned NR        = NR_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned CRD_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR-1:0]    in_vld,
    input  logic [NR-1:0]    in_req,
    input  logic [NR*DW-1:0] in_flit,
    output logic [NR-1:0]    in_pop,
    output logic [NR-1:0]    arb_req,
    input  logic [NR-1:0]    arb_grt,
    input  logic             crd_in,
    output logic             out_vld,
    output logic [DW-1:0]    out_flit,
    output logic [NR-1:0]    out_sel,
    output logic             busy,
    output logic [1:0]       err
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_nx;
    logic [NR-1:0] owner;
    logic [NR-1:0] owner_nx;
    logic [NR-1:0] cand;
    logic [DW-1:0] mux_flit;
    flit_type_t    mux_type;
    logic          send;
    logic          ill_grt;
    logic          crd_ok;
    logic          crd_ovf;

    output_port_alloc_credit_counter #(
        .DEPTH (CRD_DEPTH)
    ) u_crd (
        .clk      (clk),
        .rst      (rst),
        .inc      (crd_in),
        .dec      (send),
        .ok       (crd_ok),
        .overflow (crd_ovf)
    );

    // Crossbar mux: the grant selects while idle, the locked owner otherwise.
    always_comb begin
        cand     = (state == S_IDLE) ? arb_grt : owner;
        mux_flit = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (cand[i]) begin
                mux_flit = mux_flit | in_flit[i*DW +: DW];
            end
        end
        mux_type = flit_type_t'(mux_flit[DW-1:DW-2]);
    end

    // Next-state, request masking and pop decision.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        arb_req  = '0;
        in_pop   = '0;
        send     = 1'b0;
        ill_grt  = 1'b0;
        case (state)
            S_IDLE: begin
                for (int unsigned i = 0; i < NR; i++) begin
                    arb_req[i] = in_vld[i] & in_req[i] & crd_ok &
                                 is_head(flit_type_t'(in_flit[i*DW + DW - 2 +: 2]));
                end
                if (arb_grt != '0) begin
                    // Multi-hot grants and grants to non-requesters are dropped.
                    if ($onehot(arb_grt) && ((arb_grt & ~arb_req) == '0)) begin
                        in_pop   = arb_grt;
                        send     = 1'b1;
                        owner_nx = arb_grt;
                        if (mux_type == HEAD) begin
                            state_nx = S_LOCKED;
                        end
                    end else begin
                        ill_grt = 1'b1;
                    end
                end
            end
            default: begin
                if (((in_vld & owner) != '0) && crd_ok) begin
                    in_pop = owner;
                    send   = 1'b1;
                    if (mux_type == TAIL) begin
                        state_nx = S_IDLE;
                    end
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            owner    <= '0;
            out_vld  <= 1'b0;
            out_flit <= '0;
            out_sel  <= '0;
            busy     <= 1'b0;
            err      <= '0;
        end else begin
            state   <= state_nx;
            owner   <= owner_nx;
            out_vld <= send;
            if (send) begin
                out_flit <= mux_flit;
            end
            out_sel <= (state_nx == S_LOCKED) ? owner_nx : '0;
            busy    <= (state_nx == S_LOCKED);
            err     <= err | {ill_grt, crd_ovf};
        end
    end

endmodule

// File: tb/tb_output_port_alloc.sv
// Bench for output_port_alloc: per-input flit queues feed the DUT, the bench
// plays the arbiter, and a packet-level model predicts every output.
module tb_output_port_alloc;

    localparam int NR    = 5;
    localparam int DW    = 34;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    in_vld = '0;
    logic [NR-1:0]    in_req = '0;
    logic [NR*DW-1:0] in_flit = '0;
    logic [NR-1:0]    in_pop;
    logic [NR-1:0]    arb_req;
    logic [NR-1:0]    arb_grt = '0;
    logic             crd_in = 1'b0;
    logic             out_vld;
    logic [DW-1:0]    out_flit;
    logic [NR-1:0]    out_sel;
    logic             busy;
    logic [1:0]       err;

    always #5 clk = ~clk;

    output_port_alloc #(.NR(NR), .DW(DW), .CRD_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_req   (in_req),
        .in_flit  (in_flit),
        .in_pop   (in_pop),
        .arb_req  (arb_req),
        .arb_grt  (arb_grt),
        .crd_in   (crd_in),
        .out_vld  (out_vld),
        .out_flit (out_flit),
        .out_sel  (out_sel),
        .busy     (busy),
        .err      (err)
    );

    int checks = 0;
    int errors = 0;

    // Model: packet mode, owner index, credit count, sticky errors, expected registers.
    int            m_mode;
    int            m_own;
    int            m_crd;
    logic [1:0]    m_err;
    logic          m_vld;
    logic [DW-1:0] m_flit;
    logic [NR-1:0] m_sel;
    logic          m_busy;
    logic [DW-1:0] q [NR][$];

    // Stimulus control for directed phase.
    bit            rnd = 0;
    logic [NR-1:0] d_req = '0;
    logic          d_crd = 1'b0;
    logic [NR-1:0] d_grt = '0;
    bit            d_grt_set = 0;
    logic [NR-1:0] last_pop;
    logic [NR-1:0] last_req;
    int            seq = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input int p);
        return {t, 32'(p)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_own = 0; m_crd = DEPTH; m_err = 2'b00;
        m_vld = 1'b0; m_flit = '0; m_sel = '0; m_busy = 1'b0;
        for (int i = 0; i < NR; i++) q[i].delete();
    endtask

    task automatic step(input bit do_rst);
        logic [NR-1:0] e_req;
        logic [NR-1:0] e_pop;
        logic [NR-1:0] g;
        logic [DW-1:0] f;
        logic [1:0]    ft;
        bit            ill;
        int            idx;
        @(negedge clk);
        rst = do_rst;
        for (int i = 0; i < NR; i++) begin
            in_vld[i] = (q[i].size() > 0) && (!rnd || $urandom_range(99) < 85);
            in_flit[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : DW'($urandom);
            in_req[i] = rnd ? ($urandom_range(99) < 80) : d_req[i];
        end
        crd_in = rnd ? ($urandom_range(99) < 40) : d_crd;
        e_req = '0;
        if (m_mode == 0 && m_crd > 0) begin
            for (int i = 0; i < NR; i++) begin
                if (in_vld[i] && in_req[i]) begin
                    ft = q[i][0][DW-1:DW-2];
                    if (ft == 2'b10 || ft == 2'b11) e_req[i] = 1'b1;
                end
            end
        end
        g = '0;
        if (!rnd && d_grt_set) begin
            g = d_grt;
        end else if (rnd && $urandom_range(99) < 4) begin
            g = NR'($urandom);
        end else if (m_mode == 0 && e_req != '0) begin
            idx = rnd ? $urandom_range(NR-1) : 0;
            while (!e_req[idx]) idx = (idx + 1) % NR;
            g[idx] = 1'b1;
        end
        arb_grt = g;
        e_pop = '0;
        ill = 0;
        if (m_mode == 0) begin
            if (g != '0) begin
                if ($countones(g) == 1 && (g & ~e_req) == '0) e_pop = g;
                else ill = 1;
            end
        end else if (in_vld[m_own] && m_crd > 0) begin
            e_pop[m_own] = 1'b1;
        end
        #1;
        last_pop = in_pop;
        last_req = arb_req;
        if (!do_rst) begin
            chk("arb_req", 64'(arb_req), 64'(e_req));
            chk("in_pop", 64'(in_pop), 64'(e_pop));
        end
        if (do_rst) begin
            model_reset();
        end else begin
            if (ill) m_err[1] = 1'b1;
            if (e_pop != '0) begin
                idx = 0;
                for (int i = 0; i < NR; i++) if (e_pop[i]) idx = i;
                f = q[idx].pop_front();
                m_vld = 1'b1;
                m_flit = f;
                if (m_mode == 0) begin
                    m_own = idx;
                    if (f[DW-1:DW-2] == 2'b10) m_mode = 1;
                end else if (f[DW-1:DW-2] == 2'b01) begin
                    m_mode = 0;
                end
            end else begin
                m_vld = 1'b0;
            end
            if (crd_in && e_pop == '0) begin
                if (m_crd == DEPTH) m_err[0] = 1'b1;
                else m_crd++;
            end else if (!crd_in && e_pop != '0) begin
                m_crd--;
            end
            m_busy = (m_mode == 1);
            m_sel = '0;
            if (m_busy) m_sel[m_own] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("out_vld", 64'(out_vld), 64'(m_vld));
        chk("out_flit", 64'(out_flit), 64'(m_flit));
        chk("out_sel", 64'(out_sel), 64'(m_sel));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("err", 64'(err), 64'(m_err));
        chk("crd", 64'(dut.u_crd.cnt), 64'(m_crd));
    endtask

    task automatic add_packet(input int i);
        int len;
        len = $urandom_range(4);
        seq++;
        if (len == 0) begin
            q[i].push_back(mk(2'b11, (i << 24) | seq));
        end else begin
            q[i].push_back(mk(2'b10, (i << 24) | seq));
            for (int k = 1; k < len; k++) q[i].push_back(mk(2'b00, (i << 24) | (k << 16) | seq));
            q[i].push_back(mk(2'b01, (i << 24) | (15 << 16) | seq));
        end
    endtask

    initial begin
        model_reset();

        // Reset state
        step(1);
        chk("t1_vld", 64'(out_vld), 64'd0);
        chk("t1_sel", 64'(out_sel), 64'd0);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_crd", 64'(dut.u_crd.cnt), 64'd4);

        // Single-flit packet on input 0
        q[0].push_back(mk(2'b11, 'h11));
        d_req = 5'b00001; d_crd = 1'b1;
        step(0);
        chk("t2_pop", 64'(last_pop), 64'b00001);
        chk("t2_vld", 64'(out_vld), 64'd1);
        chk("t2_flit", 64'(out_flit), 64'h3_0000_0011);
        chk("t2_busy", 64'(busy), 64'd0);

        // Wormhole on input 2 blocks the head waiting on input 3
        q[2].push_back(mk(2'b10, 'h20));
        q[2].push_back(mk(2'b00, 'h21));
        q[2].push_back(mk(2'b00, 'h22));
        q[2].push_back(mk(2'b01, 'h23));
        q[3].push_back(mk(2'b10, 'h30));
        q[3].push_back(mk(2'b01, 'h31));
        d_req = 5'b01100;
        step(0);
        chk("t3_pop0", 64'(last_pop), 64'b00100);
        chk("t3_sel0", 64'(out_sel), 64'b00100);
        for (int k = 1; k < 4; k++) begin
            step(0);
            chk("t3_req", 64'(last_req), 64'd0);
            chk("t3_flit", 64'(out_flit), 64'(mk(k == 3 ? 2'b01 : 2'b00, 'h20 + k)));
            if (k < 3) chk("t3_sel", 64'(out_sel), 64'b00100);
        end
        chk("t3_busy_end", 64'(busy), 64'd0);
        step(0);
        chk("t3_req_next", 64'(last_req), 64'b01000);
        step(0);

        // Credit exhaustion stalls flit 5 until a credit returns
        d_crd = 1'b0; d_req = 5'b00010;
        q[1].push_back(mk(2'b10, 'h40));
        for (int k = 1; k < 4; k++) q[1].push_back(mk(2'b00, 'h40 + k));
        q[1].push_back(mk(2'b01, 'h44));
        repeat (4) step(0);
        chk("t4_crd0", 64'(dut.u_crd.cnt), 64'd0);
        repeat (2) begin
            step(0);
            chk("t4_stall", 64'(last_pop), 64'd0);
        end
        d_crd = 1'b1;
        step(0);
        chk("t4_pulse", 64'(last_pop), 64'd0);
        d_crd = 1'b0;
        step(0);
        chk("t4_release", 64'(last_pop), 64'b00010);
        chk("t4_flit", 64'(out_flit), 64'h1_0000_0044);

        // Credit overflow, then send with concurrent credit return
        d_crd = 1'b1; d_req = '0;
        repeat (4) step(0);
        chk("t5_err_pre", 64'(err), 64'd0);
        step(0);
        chk("t5_err", 64'(err), 64'b01);
        chk("t5_crd", 64'(dut.u_crd.cnt), 64'd4);
        q[0].push_back(mk(2'b11, 'h50));
        d_req = 5'b00001;
        step(0);
        chk("t5_pop", 64'(last_pop), 64'b00001);
        chk("t5_crd_same", 64'(dut.u_crd.cnt), 64'd4);

        // Illegal grants, then reset mid-packet
        d_crd = 1'b0;
        q[0].push_back(mk(2'b11, 'h60));
        d_grt_set = 1; d_grt = 5'b00011;
        step(0);
        chk("t6_multi", 64'(last_pop), 64'd0);
        chk("t6_err", 64'(err), 64'b11);
        d_grt = 5'b10000;
        step(0);
        chk("t6_nonreq", 64'(last_pop), 64'd0);
        d_grt_set = 0;
        step(0);
        q[4].push_back(mk(2'b10, 'h70));
        q[4].push_back(mk(2'b00, 'h71));
        q[4].push_back(mk(2'b01, 'h72));
        d_req = 5'b10000;
        step(0);
        chk("t6_busy", 64'(busy), 64'd1);
        step(1);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_err", 64'(err), 64'd0);
        chk("t6_rst_crd", 64'(dut.u_crd.cnt), 64'd4);

        // Randomized traffic
        rnd = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (q[i].size() == 0 && $urandom_range(99) < 30) add_packet(i);
            end
            step($urandom_range(999) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
